// File: rtl/neander_dbg_pkg.sv
// Shared NEANDER debug types: trace FSM states, trace entry layout
// and the default core widths also used by cpu_top.
package neander_dbg_pkg;

    localparam int NEANDER_ADDR_W = 8;
    localparam int NEANDER_DATA_W = 8;
    localparam int TRACE_DEPTH    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_READOUT
    } trace_state_e;

    typedef struct packed {
        logic [NEANDER_ADDR_W-1:0] pc;
        logic [NEANDER_DATA_W-1:0] ac;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/neander_trace_buffer.sv
// NEANDER on-chip trace buffer: records {PC, AC} per retired
// instruction, optional PC trigger, oldest-first readout.
module neander_trace_buffer
    import neander_dbg_pkg::*;
#(
    parameter int ADDR_W = NEANDER_ADDR_W,
    parameter int DATA_W = NEANDER_DATA_W,
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_pc,
    input  logic [DATA_W-1:0] cpu_ac,
    input  logic              cpu_step,
    input  logic              cfg_arm,
    input  logic              cfg_stop,
    input  logic              cfg_wrap,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic [CNT_W-1:0]  post_count,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_ac,
    output logic              rd_last,
    output logic              busy,
    output logic              triggered,
    output logic              overflow,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_MAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("neander_trace_buffer: DEPTH must be a power of two >= 2");
    end

    trace_state_e      state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  post_cnt;
    logic [CNT_W-1:0]  remaining;
    logic              wrap_q;
    logic [ADDR_W-1:0] trig_pc_q;
    logic [CNT_W-1:0]  post_q;

    logic              we;
    logic              hit;
    logic              go_rd;
    logic [PTR_W-1:0]  wr_ptr_n;
    logic [CNT_W-1:0]  cnt_n;
    logic [ENT_W-1:0]  rdata;

    always_comb begin
        we    = 1'b0;
        go_rd = 1'b0;
        hit   = (state == ST_ARMED) && cpu_step && (cpu_pc == trig_pc_q);
        unique case (state)
            ST_ARMED:   we = cpu_step && (wrap_q || hit);
            ST_CAPTURE: we = cpu_step;
            default:    we = 1'b0;
        endcase
        wr_ptr_n = we ? wr_ptr + 1'b1 : wr_ptr;
        cnt_n    = (we && count != FULL) ? count + 1'b1 : count;
        unique case (state)
            ST_ARMED:   go_rd = cfg_stop || (hit && post_q == '0);
            ST_CAPTURE: go_rd = cfg_stop ||
                                (we && ((!wrap_q && cnt_n == FULL) ||
                                        (triggered && post_cnt == ONE)));
            default:    go_rd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            remaining <= '0;
            wrap_q    <= 1'b0;
            trig_pc_q <= '0;
            post_q    <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr_n;
                count  <= cnt_n;
                if (count == FULL) overflow <= 1'b1;
            end
            // A full buffer's oldest entry sits at wr_ptr; DEPTH wraps to 0.
            if (go_rd) begin
                state     <= ST_READOUT;
                rd_ptr    <= wr_ptr_n - cnt_n[PTR_W-1:0];
                remaining <= cnt_n;
            end
            unique case (state)
                ST_IDLE: begin
                    if (cfg_arm) begin
                        wrap_q    <= cfg_wrap;
                        trig_pc_q <= trig_pc;
                        post_q    <= (post_count > POST_MAX) ? POST_MAX : post_count;
                        count     <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        post_cnt  <= '0;
                        triggered <= 1'b0;
                        overflow  <= 1'b0;
                        state     <= trig_en ? ST_ARMED : ST_CAPTURE;
                    end
                end
                ST_ARMED: begin
                    if (hit) begin
                        triggered <= 1'b1;
                        post_cnt  <= post_q;
                        if (!go_rd) state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (we && triggered) post_cnt <= post_cnt - 1'b1;
                end
                ST_READOUT: begin
                    if (remaining == '0) begin
                        state <= ST_IDLE;
                    end else if (rd_ready) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata ({cpu_pc, cpu_ac}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign rd_valid = (state == ST_READOUT) && (remaining != '0);
    assign rd_last  = rd_valid && (remaining == ONE);
    assign rd_pc    = rdata[ENT_W-1:DATA_W];
    assign rd_ac    = rdata[DATA_W-1:0];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_neander_trace_buffer.sv
// Self-checking bench for neander_trace_buffer (DEPTH=8) against a
// queue-based capture model; directed plan cases plus random runs.
module tb_neander_trace_buffer;
    import neander_dbg_pkg::*;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cpu_pc = '0;
    logic [7:0] cpu_ac = '0;
    logic       cpu_step = 1'b0;
    logic       cfg_arm = 1'b0;
    logic       cfg_stop = 1'b0;
    logic       cfg_wrap = 1'b0;
    logic       trig_en = 1'b0;
    logic [7:0] trig_pc = '0;
    logic [3:0] post_count = '0;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_pc;
    logic [7:0] rd_ac;
    logic       rd_last;
    logic       busy;
    logic       triggered;
    logic       overflow;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   st_pc [64];
    logic [7:0]   st_ac [64];
    trace_entry_t exp_q [$];

    neander_trace_buffer #(
        .ADDR_W (8),
        .DATA_W (8),
        .DEPTH  (D),
        .CNT_W  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_pc     (cpu_pc),
        .cpu_ac     (cpu_ac),
        .cpu_step   (cpu_step),
        .cfg_arm    (cfg_arm),
        .cfg_stop   (cfg_stop),
        .cfg_wrap   (cfg_wrap),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_pc      (rd_pc),
        .rd_ac      (rd_ac),
        .rd_last    (rd_last),
        .busy       (busy),
        .triggered  (triggered),
        .overflow   (overflow),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Capture outcome from the rules: which steps are recorded, where
    // the capture ends, then keep the newest min(total, D) samples.
    task automatic model(input bit wrap, input bit ten, input logic [7:0] tpc,
                         input int post, input int n, input int stop_idx,
                         output int end_i, output int cnt,
                         output bit trig, output bit ovf);
        trace_entry_t rec [$];
        int  total = 0;
        bit  armed = ten;
        int  pend = (post > D - 1) ? D - 1 : post;
        trig  = 1'b0;
        end_i = -1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            bit hit = (st_pc[i] == tpc);
            bit take = armed ? (wrap || hit) : 1'b1;
            bit fin = 1'b0;
            if (take) begin
                rec.push_back('{pc: st_pc[i], ac: st_ac[i]});
                total++;
            end
            if (armed && hit) begin
                trig  = 1'b1;
                armed = 1'b0;
                fin   = (pend == 0);
            end else if (!armed && trig) begin
                pend--;
                fin = (pend == 0);
            end
            if (!armed && !wrap && total == D) fin = 1'b1;
            if (i == stop_idx) fin = 1'b1;
            if (fin) begin
                end_i = i;
                break;
            end
        end
        cnt = (total > D) ? D : total;
        ovf = (total > D);
        for (int k = total - cnt; k < total; k++) exp_q.push_back(rec[k]);
    endtask

    // rmode: 0 random ready, 1 alternating 0/1, 2 always ready
    task automatic drain(input string name, input int rmode);
        int         guard = 0;
        int         hs = 0;
        int         want = exp_q.size();
        bit         hold = 1'b0;
        logic [7:0] prev_pc = '0;
        logic [7:0] prev_ac = '0;
        bit         rdy;
        while (exp_q.size() > 0 && guard < 300) begin
            guard++;
            rdy = (rmode == 0) ? 1'($urandom_range(0, 1)) :
                  (rmode == 1) ? 1'(guard % 2 == 0) : 1'b1;
            rd_ready = rdy;
            vectors++;
            if (rd_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s rd_valid: got %b want 1 (%0d left)",
                         name, rd_valid, exp_q.size());
            end else begin
                vectors++;
                if (rd_pc !== exp_q[0].pc || rd_ac !== exp_q[0].ac) begin
                    miscompares++;
                    $display("FAIL %s entry: got pc=%0d ac=%0d want pc=%0d ac=%0d",
                             name, rd_pc, rd_ac, exp_q[0].pc, exp_q[0].ac);
                end
                vectors++;
                if (rd_last !== (exp_q.size() == 1)) begin
                    miscompares++;
                    $display("FAIL %s rd_last: got %b want %b at pc=%0d",
                             name, rd_last, exp_q.size() == 1, exp_q[0].pc);
                end
                if (hold) begin
                    vectors++;
                    if (rd_pc !== prev_pc || rd_ac !== prev_ac) begin
                        miscompares++;
                        $display("FAIL %s stable: got pc=%0d want pc=%0d",
                                 name, rd_pc, prev_pc);
                    end
                end
                hold    = !rdy;
                prev_pc = rd_pc;
                prev_ac = rd_ac;
                if (rdy) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
            end
            tick;
        end
        rd_ready = 1'b0;
        vectors++;
        if (hs != want) begin
            miscompares++;
            $display("FAIL %s handshakes: got %0d want %0d", name, hs, want);
        end
    endtask

    task automatic run_capture(input string name, input bit wrap, input bit ten,
                               input logic [7:0] tpc, input int post,
                               input int n, input int stop_idx,
                               input bit gaps, input int rmode);
        int end_i;
        int ecnt;
        bit etrig;
        bit eovf;
        bit ev;
        model(wrap, ten, tpc, post, n, stop_idx, end_i, ecnt, etrig, eovf);
        cfg_wrap   = wrap;
        trig_en    = ten;
        trig_pc    = tpc;
        post_count = 4'(post);
        cfg_arm    = 1'b1;
        tick;
        cfg_arm = 1'b0;
        for (int i = 0; i < n; i++) begin
            cpu_pc   = st_pc[i];
            cpu_ac   = st_ac[i];
            cpu_step = 1'b1;
            cfg_stop = (i == stop_idx);
            tick;
            cpu_step = 1'b0;
            cfg_stop = 1'b0;
            ev = (end_i >= 0) && (i >= end_i) && (ecnt > 0);
            vectors++;
            if (rd_valid !== ev) begin
                miscompares++;
                $display("FAIL %s valid_after_step%0d: got %b want %b",
                         name, i, rd_valid, ev);
            end
            if (gaps) repeat ($urandom_range(0, 2)) tick;
        end
        if (end_i < 0) begin
            cfg_stop = 1'b1;
            tick;
            cfg_stop = 1'b0;
            vectors++;
            if (rd_valid !== (ecnt > 0)) begin
                miscompares++;
                $display("FAIL %s valid_after_stop: got %b want %b",
                         name, rd_valid, ecnt > 0);
            end
        end
        drain(name, rmode);
        tick;
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: got busy=%b rd_valid=%b want 0/0",
                     name, busy, rd_valid);
        end
        vectors++;
        if (count !== 4'(ecnt) || triggered !== etrig || overflow !== eovf) begin
            miscompares++;
            $display("FAIL %s status: got cnt=%0d trg=%b ovf=%b want cnt=%0d trg=%b ovf=%b",
                     name, count, triggered, overflow, ecnt, etrig, eovf);
        end
    endtask

    task automatic load_ramp(input int base, input int n, input int acmul);
        for (int i = 0; i < n; i++) begin
            st_pc[i] = 8'(base + i);
            st_ac[i] = 8'((base + i) * acmul);
        end
    endtask

    task automatic test_reset;
        #3;
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 ||
            triggered !== 1'b0 || overflow !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b v=%b l=%b t=%b o=%b c=%0d want all 0",
                     busy, rd_valid, rd_last, triggered, overflow, count);
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_stop_mode;
        load_ramp(0, 10, 2);
        run_capture("stop_mode", 1'b0, 1'b0, 8'd0, 0, 10, -1, 1'b0, 2);
    endtask

    task automatic test_wrap_trigger;
        load_ramp(10, 21, 3);
        run_capture("wrap_trig", 1'b1, 1'b1, 8'd20, 3, 21, -1, 1'b0, 2);
    endtask

    task automatic test_backpressure;
        load_ramp(0, 10, 2);
        run_capture("backpressure", 1'b0, 1'b0, 8'd0, 0, 10, -1, 1'b0, 1);
    endtask

    task automatic test_stop_armed;
        load_ramp(1, 3, 5);
        run_capture("stop_armed", 1'b1, 1'b1, 8'hFF, 2, 3, -1, 1'b0, 2);
    endtask

    task automatic test_arm_collision;
        cfg_wrap = 1'b0;
        trig_en  = 1'b0;
        cfg_arm  = 1'b1;
        cpu_step = 1'b1;
        cpu_pc   = 8'd5;
        cpu_ac   = 8'd9;
        tick;
        cfg_arm  = 1'b0;
        cpu_step = 1'b0;
        vectors++;
        if (busy !== 1'b1 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL arm_collision: got busy=%b cnt=%0d want 1/0", busy, count);
        end
        cfg_stop = 1'b1;
        tick;
        cfg_stop = 1'b0;
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_valid: got %b want 0", rd_valid);
        end
        tick;
        vectors++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL empty_idle: got busy=%b v=%b cnt=%0d want 0/0/0",
                     busy, rd_valid, count);
        end
    endtask

    task automatic test_async_reset;
        cfg_wrap = 1'b0;
        trig_en  = 1'b0;
        cfg_arm  = 1'b1;
        tick;
        cfg_arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_pc   = 8'(40 + i);
            cpu_ac   = 8'(i);
            cpu_step = 1'b1;
            tick;
        end
        cpu_step = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || count !== 4'd0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got busy=%b cnt=%0d v=%b want 0/0/0",
                     busy, count, rd_valid);
        end
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        load_ramp(0, 10, 2);
        run_capture("after_reset", 1'b0, 1'b0, 8'd0, 0, 10, -1, 1'b0, 2);
    endtask

    task automatic test_random;
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(3, 30);
            int stop_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 35) : -1;
            for (int i = 0; i < n; i++) begin
                st_pc[i] = 8'($urandom_range(0, 31));
                st_ac[i] = 8'($urandom);
            end
            run_capture($sformatf("random%0d", r), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
                        $urandom_range(0, 15), n, stop_idx, 1'b1, 0);
        end
    endtask

    initial begin
        test_reset;
        test_stop_mode;
        test_wrap_trigger;
        test_backpressure;
        test_stop_armed;
        test_arm_collision;
        test_async_reset;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neander_trace_buffer.md
Name: neander_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the NEANDER core. It is the hardware successor of the bench-side PC/AC monitor.
- Records {PC, AC} samples on each instruction-retire strobe into a DEPTH-entry buffer, with an optional PC-match trigger and pre/post-trigger history.
- Plays the capture back oldest-first over a valid/ready port.
- Sits beside cpu_top on the dbg_pc/dbg_ac debug taps. Feeds the TinyTapeout debug mux.

Parameters:
- ADDR_W, 8, PC width.
- DATA_W, 8, AC width.
- DEPTH, 16, buffer entries; power of two, ≥2 (elaboration error otherwise).
- CNT_W, $clog2(DEPTH+1), width of counts.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_pc  in  ADDR_W  core PC (dbg_pc).
- cpu_ac  in  DATA_W  core AC (dbg_ac).
- cpu_step  in  1  one-cycle strobe; PC/AC valid this cycle.
- cfg_arm  in  1  pulse: start a capture (honoured only in IDLE).
- cfg_stop  in  1  pulse: force end of capture.
- cfg_wrap  in  1  0 = stop-on-full, 1 = circular; sampled at arm.
- trig_en  in  1  enable PC-match trigger; sampled at arm.
- trig_pc  in  ADDR_W  trigger PC; sampled at arm.
- post_count  in  CNT_W  samples after trigger sample (0..DEPTH-1, larger saturates to DEPTH-1); sampled at arm.
- rd_valid  out  1  readout entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_pc  out  ADDR_W  entry PC.
- rd_ac  out  DATA_W  entry AC.
- rd_last  out  1  entry is the final one.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger fired in current/last capture.
- overflow  out  1  circular mode overwrote at least one entry.
- count  out  CNT_W  valid entries, saturating at DEPTH.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; wr_ptr, rd_ptr, count, post counter=0; rd_valid, rd_last, busy, triggered, overflow=0.
  - Buffer RAM is not reset; rd_pc/rd_ac are don't-care while rd_valid=0.
  - Outputs change immediately on reset, without a clock edge.
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE:
  - cfg_arm latches the config.
  - Clears count, pointers, triggered and overflow.
  - Next state is ARMED if trig_en, else CAPTURE.
  - cpu_step in the arm cycle is NOT recorded.
- ARMED:
  - wrap=1: each cpu_step writes a pre-trigger sample circularly.
  - wrap=0: nothing is written.
  - cpu_step with cpu_pc==trig_pc writes that sample, sets triggered, loads the post counter with post_count, and moves to CAPTURE.
    - post_count=0 goes straight to READOUT instead.
- CAPTURE:
  - Each cpu_step writes mem[wr_ptr] and increments wr_ptr modulo DEPTH.
  - count saturates at DEPTH.
  - Writing when count==DEPTH sets overflow (wrap only).
  - Exit to READOUT after the write that satisfies either:
    - wrap=0 and count reaches DEPTH;
    - triggered and the post counter reaches 0 (decrements per write).
  - wrap=1 without trigger runs until cfg_stop.
- cfg_stop:
  - In ARMED or CAPTURE: next state READOUT. A same-cycle cpu_step is still written first.
  - Ignored in IDLE and READOUT.
- READOUT:
  - On entry, rd_ptr = (count==DEPTH) ? wr_ptr : wr_ptr - count (mod DEPTH).
  - rd_valid=1 from the first cycle in READOUT while entries remain.
  - rd_pc/rd_ac = mem[rd_ptr]; reads are combinational and held stable while rd_valid && !rd_ready.
  - Handshake is rd_valid && rd_ready; on it, rd_ptr advances and the remaining count decrements.
  - rd_last=1 on the entry where remaining==1.
  - After the last handshake: IDLE, rd_valid=0. count, triggered and overflow hold until the next arm.
  - count==0 on entry: go to IDLE next cycle with rd_valid never asserted.
- cpu_step, cfg_arm and cfg_stop outside the states above are ignored.
- Samples arriving in READOUT are dropped.
- Arm during busy is ignored.

Decomposition:
- Package neander_dbg_pkg holds:
  - trace_state_e enum (IDLE, ARMED, CAPTURE, READOUT);
  - trace_entry_t packed struct {pc, ac};
  - default width constants shared with cpu_top.
- Sub-module trace_ram: DEPTH×(ADDR_W+DATA_W), one synchronous write port, one asynchronous read port.
- FSM, pointers and counters live in the top.

Test Plan:
- Stop mode, no trigger, DEPTH=8:
  - Stimulus: arm wrap=0; 10 steps with pc=0..9, ac=2*pc.
  - Required: READOUT after the 8th step; 8 entries pc 0..7 with ac 0..14; rd_last on pc=7; overflow=0; count=8.
- Wrap with trigger:
  - Stimulus: trig_pc=20, post_count=3; steps pc=10..30.
  - Required: READOUT after pc=23 is written; entries pc 16..23 oldest-first; triggered=1; overflow=1.
- Backpressure:
  - Stimulus: repeat case 1 with rd_ready alternating 0/1.
  - Required: rd_pc stable while rd_ready=0; exactly 8 handshakes; no duplicates or drops.
- Stop while armed:
  - Stimulus: wrap=1, trig_pc=0xFF never hit; steps pc 1,2,3; cfg_stop.
  - Required: 3 entries pc 1,2,3; triggered=0; rd_last on pc=3.
- Arm collision and empty:
  - Stimulus: cfg_arm coincident with cpu_step pc=5, then cfg_stop with no further steps.
  - Required: count=0; rd_valid never asserted; returns to IDLE.
- Async reset:
  - Stimulus: rst_n low mid-CAPTURE after 4 steps, between clock edges.
  - Required: busy=0, count=0, rd_valid=0 immediately; new arm behaves as case 1.
